// File: rtl/lsu_pkg.sv
// Shared types, encodings and helpers for the load/store unit.
// Defining LSU_SPLIT_MISALIGN_EN adds the ACCESS2/WAIT2 states used to split misaligned accesses.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
`ifdef LSU_SPLIT_MISALIGN_EN
        ,
        ACCESS2,
        WAIT2
`endif
    } state_t;

    localparam logic [1:0] WS_NONE = 2'b00;
    localparam logic [1:0] WS_BYTE = 2'b01;
    localparam logic [1:0] WS_HALF = 2'b10;
    localparam logic [1:0] WS_WORD = 2'b11;

    localparam logic [2:0] LS_LB  = 3'b000;
    localparam logic [2:0] LS_LH  = 3'b001;
    localparam logic [2:0] LS_LW  = 3'b010;
    localparam logic [2:0] LS_LBU = 3'b100;
    localparam logic [2:0] LS_LHU = 3'b101;

    // Unshifted byte-enable pattern for an access size.
    function automatic logic [3:0] byte_mask(input logic [1:0] ws);
        case (ws)
            WS_BYTE: return 4'b0001;
            WS_HALF: return 4'b0011;
            WS_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic lsize_legal(input logic [2:0] ls);
        return ls inside {LS_LB, LS_LH, LS_LW, LS_LBU, LS_LHU};
    endfunction

    // Map a load funct3 onto the store size encoding (byte/half/word).
    function automatic logic [1:0] load_ws(input logic [2:0] ls);
        return ls[1:0] + 2'd1;
    endfunction

    // Replicate right-justified store data across all lanes.
    function automatic logic [31:0] lane_data(input logic [31:0] d, input logic [1:0] ws);
        case (ws)
            WS_BYTE: return {4{d[7:0]}};
            WS_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shift a (possibly two-word) read right by the byte offset,
// then sign- or zero-extend per funct3. data_hi is zero for single-word loads.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] data_lo,
    input  logic [31:0] data_hi,
    input  logic [1:0]  offset,
    input  logic [2:0]  lsize,
    output logic [31:0] result_c
);

    logic [31:0] word;

    always_comb begin
        word = 32'({data_hi, data_lo} >> {offset, 3'b000});
        case (lsize)
            LS_LB:   result_c = {{24{word[7]}}, word[7:0]};
            LS_LH:   result_c = {{16{word[15]}}, word[15:0]};
            LS_LW:   result_c = word;
            LS_LBU:  result_c = {24'd0, word[7:0]};
            LS_LHU:  result_c = {16'd0, word[15:0]};
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core and a word-wide synchronous RAM with valid/ready handshake.
// LSU_SPLIT_MISALIGN_EN: misaligned half/word accesses become two RAM accesses instead of errors.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_is_store,
    input  logic [1:0]        req_wsize,
    input  logic [2:0]        req_lsize,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [3:0]        ram_be,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int unsigned WADDR_W = ADDR_W - 2;
    localparam int unsigned CNT_W   = 2;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RAM_LATENCY - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             store_q;
    logic [1:0]       off_q;
    logic [2:0]       lsize_q;

    logic             accept;
    logic [1:0]       in_ws;
    logic [1:0]       in_off;
    logic             in_illegal;
    logic             in_misal;
    logic             in_err;
    logic [3:0]       in_be;
    logic [31:0]      in_wdata;

    logic [31:0]      align_lo, align_hi, align_out;

    logic               req_ready_nxt, resp_valid_nxt, resp_error_nxt;
    logic [31:0]        resp_rdata_nxt;
    logic               ram_en_nxt, ram_we_nxt;
    logic [WADDR_W-1:0] ram_addr_nxt;
    logic [3:0]         ram_be_nxt;
    logic [31:0]        ram_wdata_nxt;

`ifdef LSU_SPLIT_MISALIGN_EN
    logic [1:0]         ws_q;
    logic [31:0]        wdata_q;
    logic               split_q;
    logic [31:0]        lo_q, lo_nxt;
    logic               in_split;
    logic [WADDR_W-1:0] acc2_addr;
    logic [3:0]         acc2_be;
    logic [31:0]        acc2_wdata;
`endif

    assign accept = req_valid && req_ready;

    // Decode the incoming request: size, legality and alignment.
    always_comb begin
        in_off     = req_addr[1:0];
        in_ws      = req_is_store ? req_wsize : load_ws(req_lsize);
        in_illegal = req_is_store ? (req_wsize == WS_NONE) : !lsize_legal(req_lsize);
        in_misal   = ((in_ws == WS_HALF) && in_off[0]) || ((in_ws == WS_WORD) && (in_off != 2'b00));
        in_be      = byte_mask(in_ws) << in_off;
`ifdef LSU_SPLIT_MISALIGN_EN
        in_err     = in_illegal;
        in_split   = in_misal && !in_illegal;
        in_wdata   = in_split ? (req_wdata << {in_off, 3'b000}) : lane_data(req_wdata, in_ws);
`else
        in_err     = in_illegal || in_misal;
        in_wdata   = lane_data(req_wdata, in_ws);
`endif
    end

`ifdef LSU_SPLIT_MISALIGN_EN
    // Second access covers the bytes that spilled past the first word (off is 1..3 here).
    assign acc2_addr  = ram_addr + WADDR_W'(1);
    assign acc2_be    = byte_mask(ws_q) >> (3'd4 - {1'b0, off_q});
    assign acc2_wdata = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
    assign align_lo   = (state == WAIT2) ? lo_q : ram_rdata;
    assign align_hi   = (state == WAIT2) ? ram_rdata : '0;
`else
    assign align_lo   = ram_rdata;
    assign align_hi   = '0;
`endif

    lsu_load_align u_align (
        .data_lo  (align_lo),
        .data_hi  (align_hi),
        .offset   (off_q),
        .lsize    (lsize_q),
        .result_c (align_out)
    );

    // Next state and next registered outputs.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt_q;
        resp_valid_nxt = 1'b0;
        resp_error_nxt = 1'b0;
        resp_rdata_nxt = '0;
        ram_en_nxt     = 1'b0;
        ram_we_nxt     = 1'b0;
        ram_be_nxt     = '0;
        ram_addr_nxt   = ram_addr;
        ram_wdata_nxt  = ram_wdata;
`ifdef LSU_SPLIT_MISALIGN_EN
        lo_nxt         = lo_q;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_err) begin
                        state_nxt      = RESP;
                        resp_valid_nxt = 1'b1;
                        resp_error_nxt = 1'b1;
                    end else begin
                        state_nxt     = ACCESS;
                        ram_en_nxt    = 1'b1;
                        ram_we_nxt    = req_is_store;
                        ram_addr_nxt  = req_addr[ADDR_W-1:2];
                        ram_be_nxt    = in_be;
                        ram_wdata_nxt = in_wdata;
                    end
                end
            end
            ACCESS: begin
                if (!store_q) begin
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                end
`ifdef LSU_SPLIT_MISALIGN_EN
                else if (split_q) begin
                    state_nxt     = ACCESS2;
                    ram_en_nxt    = 1'b1;
                    ram_we_nxt    = 1'b1;
                    ram_addr_nxt  = acc2_addr;
                    ram_be_nxt    = acc2_be;
                    ram_wdata_nxt = acc2_wdata;
                end
`endif
                else begin
                    state_nxt      = RESP;
                    resp_valid_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == LAT_LAST) begin
`ifdef LSU_SPLIT_MISALIGN_EN
                    if (split_q) begin
                        lo_nxt        = ram_rdata;
                        state_nxt     = ACCESS2;
                        ram_en_nxt    = 1'b1;
                        ram_addr_nxt  = acc2_addr;
                        ram_be_nxt    = acc2_be;
                    end else
`endif
                    begin
                        state_nxt      = RESP;
                        resp_valid_nxt = 1'b1;
                        resp_rdata_nxt = align_out;
                    end
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
`ifdef LSU_SPLIT_MISALIGN_EN
            ACCESS2: begin
                if (store_q) begin
                    state_nxt      = RESP;
                    resp_valid_nxt = 1'b1;
                end else begin
                    state_nxt = WAIT2;
                    cnt_nxt   = '0;
                end
            end
            WAIT2: begin
                if (cnt_q == LAT_LAST) begin
                    state_nxt      = RESP;
                    resp_valid_nxt = 1'b1;
                    resp_rdata_nxt = align_out;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
`endif
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        req_ready_nxt = (state_nxt == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_be     <= '0;
            ram_wdata  <= '0;
`ifdef LSU_SPLIT_MISALIGN_EN
            lo_q       <= '0;
`endif
        end else begin
            state      <= state_nxt;
            cnt_q      <= cnt_nxt;
            req_ready  <= req_ready_nxt;
            resp_valid <= resp_valid_nxt;
            resp_rdata <= resp_rdata_nxt;
            resp_error <= resp_error_nxt;
            ram_en     <= ram_en_nxt;
            ram_we     <= ram_we_nxt;
            ram_addr   <= ram_addr_nxt;
            ram_be     <= ram_be_nxt;
            ram_wdata  <= ram_wdata_nxt;
`ifdef LSU_SPLIT_MISALIGN_EN
            lo_q       <= lo_nxt;
`endif
        end
    end

    // Request capture on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_q <= 1'b0;
            off_q   <= '0;
            lsize_q <= '0;
`ifdef LSU_SPLIT_MISALIGN_EN
            ws_q    <= '0;
            wdata_q <= '0;
            split_q <= 1'b0;
`endif
        end else if (accept) begin
            store_q <= req_is_store;
            off_q   <= in_off;
            lsize_q <= req_lsize;
`ifdef LSU_SPLIT_MISALIGN_EN
            ws_q    <= in_ws;
            wdata_q <= req_wdata;
            split_q <= in_split;
`endif
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random traffic
// checked against a byte-addressed memory model. Honors LSU_SPLIT_MISALIGN_EN.
module tb_load_store_unit;

    localparam int unsigned RAM_LATENCY = 1;
`ifdef LSU_SPLIT_MISALIGN_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_is_store = 1'b0;
    logic [1:0]  req_wsize = '0;
    logic [2:0]  req_lsize = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        ram_en;
    logic        ram_we;
    logic [29:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int n_checks = 0;
    int n_bad    = 0;

    bit   [31:0] ram_mem [256];
    logic [31:0] rd_pipe [RAM_LATENCY];
    bit   [7:0]  ref_mem [1024];

    int          got_lat, got_nacc;
    logic        got_err;
    logic [31:0] got_rdata;
    logic [29:0] acc_addr [2];
    logic [3:0]  acc_be [2];
    logic [31:0] acc_wdata [2];
    logic        acc_we;

    int          exp_lat, exp_nacc;
    logic        exp_err;
    logic [31:0] exp_rdata;

    logic [31:0] r_addr, r_data;
    logic        r_st;
    logic [1:0]  r_ws;
    logic [2:0]  r_ls;
    logic        any_resp;

    load_store_unit #(
        .ADDR_W      (32),
        .RAM_LATENCY (RAM_LATENCY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_is_store (req_is_store),
        .req_wsize    (req_wsize),
        .req_lsize    (req_lsize),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_be       (ram_be),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: byte-enabled write, read data after RAM_LATENCY cycles.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) ram_mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            rd_pipe[0] <= ram_mem[ram_addr[7:0]];
        end
        for (int i = 1; i < RAM_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RAM_LATENCY-1];

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected outcome of one request, derived from byte-level memory semantics.
    task automatic ref_op(input logic [31:0] a, input logic st, input logic [1:0] ws,
                          input logic [2:0] ls, input logic [31:0] wd);
        int nb = 1;
        bit illegal = 1'b0;
        bit sgn = 1'b0;
        bit misal;
        logic [31:0] v = '0;
        if (st) begin
            illegal = (ws == 2'd0);
            nb = (ws == 2'd3) ? 4 : int'(ws);
        end else begin
            case (ls)
                3'b000:  begin nb = 1; sgn = 1'b1; end
                3'b001:  begin nb = 2; sgn = 1'b1; end
                3'b010:  nb = 4;
                3'b100:  nb = 1;
                3'b101:  nb = 2;
                default: illegal = 1'b1;
            endcase
        end
        misal     = !illegal && ((a % 32'(nb)) != 0);
        exp_err   = illegal || (misal && !SPLIT);
        exp_nacc  = exp_err ? 0 : (misal ? 2 : 1);
        exp_lat   = exp_err ? 1 : st ? (misal ? 3 : 2)
                                     : (misal ? 3 + 2 * int'(RAM_LATENCY) : 2 + int'(RAM_LATENCY));
        exp_rdata = '0;
        if (!exp_err) begin
            for (int i = 0; i < nb; i++) begin
                if (st) ref_mem[(a + 32'(i)) & 32'h3FF] = wd[8*i +: 8];
                else    v[8*i +: 8] = ref_mem[(a + 32'(i)) & 32'h3FF];
            end
            if (!st) begin
                if (sgn && v[8*nb-1])
                    for (int j = 8 * nb; j < 32; j++) v[j] = 1'b1;
                exp_rdata = v;
            end
        end
    endtask

    // Issue one request, record the RAM accesses and response, and check against the model.
    task automatic do_txn(input logic [31:0] a, input logic st, input logic [1:0] ws,
                          input logic [2:0] ls, input logic [31:0] wd);
        int waited = 0;
        bit seen = 1'b0;
        while (!req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check_eq("req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_addr = a; req_is_store = st;
        req_wsize = ws; req_lsize = ls; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        ref_op(a, st, ws, ls, wd);
        got_lat = 0; got_nacc = 0; got_err = 1'b0; got_rdata = '0;
        acc_addr[0] = 'x; acc_addr[1] = 'x; acc_be[0] = 'x; acc_be[1] = 'x;
        acc_wdata[0] = 'x; acc_wdata[1] = 'x; acc_we = 1'bx;
        for (int k = 1; k <= 24 && !seen; k++) begin
            if (ram_en) begin
                if (got_nacc < 2) begin
                    acc_addr[got_nacc]  = ram_addr;
                    acc_be[got_nacc]    = ram_be;
                    acc_wdata[got_nacc] = ram_wdata;
                end
                if (got_nacc == 0) acc_we = ram_we;
                got_nacc++;
            end
            if (resp_valid) begin
                seen = 1'b1; got_lat = k; got_err = resp_error; got_rdata = resp_rdata;
            end else begin
                @(posedge clk); #1;
            end
        end
        check_eq("resp_seen", 32'(seen), 32'd1);
        check_eq("latency", 32'(got_lat), 32'(exp_lat));
        check_eq("resp_error", 32'(got_err), 32'(exp_err));
        check_eq("resp_rdata", got_rdata, exp_rdata);
        check_eq("ram_accesses", 32'(got_nacc), 32'(exp_nacc));
        if (got_nacc > 0) check_eq("ram_we", 32'(acc_we), 32'(st));
        if (seen) begin
            @(posedge clk); #1;
            check_eq("resp_pulse", 32'(resp_valid), 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
        check_eq({tag, "_valid"}, 32'(resp_valid), 32'd0);
        check_eq({tag, "_rdata"}, resp_rdata, 32'd0);
        check_eq({tag, "_error"}, 32'(resp_error), 32'd0);
        check_eq({tag, "_en"}, 32'(ram_en), 32'd0);
        check_eq({tag, "_we"}, 32'(ram_we), 32'd0);
        check_eq({tag, "_addr"}, 32'(ram_addr), 32'd0);
        check_eq({tag, "_be"}, 32'(ram_be), 32'd0);
        check_eq({tag, "_wdata"}, ram_wdata, 32'd0);
    endtask

    function automatic logic [2:0] pick_ls();
        logic [2:0] legal [5];
        logic [2:0] bad [3];
        legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b010;
        legal[3] = 3'b100; legal[4] = 3'b101;
        bad[0] = 3'b011; bad[1] = 3'b110; bad[2] = 3'b111;
        if ($urandom_range(0, 9) == 0) return bad[$urandom_range(0, 2)];
        return legal[$urandom_range(0, 4)];
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Byte store to lane 2.
        do_txn(32'h0000_0102, 1'b1, 2'd1, 3'd0, 32'h0000_00AB);
        check_eq("sb_be", 32'(acc_be[0]), 32'h4);
        check_eq("sb_wdata", acc_wdata[0], 32'hABABABAB);
        check_eq("sb_addr", 32'(acc_addr[0]), 32'h40);
        check_eq("sb_lat", 32'(got_lat), 32'd2);

        // Signed/unsigned byte loads from the top lane.
        do_txn(32'h0000_0100, 1'b1, 2'd3, 3'd0, 32'h80FF1234);
        do_txn(32'h0000_0103, 1'b0, 2'd0, 3'b000, 32'd0);
        check_eq("lb_val", got_rdata, 32'hFFFFFF80);
        check_eq("lb_lat", 32'(got_lat), 32'(2 + RAM_LATENCY));
        do_txn(32'h0000_0103, 1'b0, 2'd0, 3'b100, 32'd0);
        check_eq("lbu_val", got_rdata, 32'h00000080);

        // Signed/unsigned half loads from the upper half.
        do_txn(32'h0000_0100, 1'b1, 2'd3, 3'd0, 32'h8001ABCD);
        do_txn(32'h0000_0102, 1'b0, 2'd0, 3'b001, 32'd0);
        check_eq("lh_val", got_rdata, 32'hFFFF8001);
        do_txn(32'h0000_0102, 1'b0, 2'd0, 3'b101, 32'd0);
        check_eq("lhu_val", got_rdata, 32'h00008001);

`ifdef LSU_SPLIT_MISALIGN_EN
        do_txn(32'h0000_00FE, 1'b1, 2'd3, 3'd0, 32'h11223344);
        check_eq("split_be0", 32'(acc_be[0]), 32'hC);
        check_eq("split_addr0", 32'(acc_addr[0]), 32'h3F);
        check_eq("split_be1", 32'(acc_be[1]), 32'h3);
        check_eq("split_addr1", 32'(acc_addr[1]), 32'h40);
        do_txn(32'h0000_00FE, 1'b0, 2'd0, 3'b010, 32'd0);
        check_eq("split_lw", got_rdata, 32'h11223344);
`else
        do_txn(32'h0000_0101, 1'b0, 2'd0, 3'b010, 32'd0);
        check_eq("mis_err", 32'(got_err), 32'd1);
        check_eq("mis_lat", 32'(got_lat), 32'd1);
        check_eq("mis_no_ram", 32'(got_nacc), 32'd0);
`endif

        // Reset in the middle of a load's WAIT state.
        req_valid = 1'b1; req_addr = 32'h0000_0100; req_is_store = 1'b0; req_lsize = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("rst_pre_en", 32'(ram_en), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        any_resp = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (resp_valid) any_resp = 1'b1;
        end
        check_eq("midrst_no_resp", 32'(any_resp), 32'd0);
        rst = 1'b0;
        do_txn(32'h0000_0100, 1'b0, 2'd0, 3'b010, 32'd0);

        // Fill every RAM word, then random mixed traffic.
        for (int i = 0; i < 256; i++) begin
            r_addr = $urandom;
            r_addr[9:0] = 10'(i * 4);
            do_txn(r_addr, 1'b1, 2'd3, 3'd0, $urandom);
        end
        for (int i = 0; i < 300; i++) begin
            r_addr = $urandom;
            r_st   = 1'($urandom_range(0, 1));
            r_ws   = ($urandom_range(0, 15) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            r_ls   = pick_ls();
            r_data = $urandom;
            do_txn(r_addr, r_st, r_ws, r_ls, r_data);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
